// File: rtl/conv_encoder_param_pkg.sv
// Shared types and default constants for the tail-biting rate-1/3 convolutional encoder.
// Package name is conv_pkg; it is imported by the interface, the output FIFO and the encoder top.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ENC,
        ST_DRAIN
    } conv_state_e;

    localparam int K_DEFAULT = 7;

    // Generator taps: MSB multiplies the current input bit.
    localparam logic [K_DEFAULT-1:0] G0_DEFAULT = 7'o133;
    localparam logic [K_DEFAULT-1:0] G1_DEFAULT = 7'o171;
    localparam logic [K_DEFAULT-1:0] G2_DEFAULT = 7'o165;

    localparam int MAX_LEN_DEFAULT    = 768;
    localparam int FIFO_DEPTH_DEFAULT = 16;
    localparam int LW_DEFAULT         = $clog2(MAX_LEN_DEFAULT + 1);

endpackage

// File: rtl/conv_encoder_param_if.sv
// Control, input byte stream, output triplet stream and status of the convolutional encoder.
// The slave modport is the encoder side; the master modport is the block driver/consumer side.
interface conv_encoder_param_if
    import conv_pkg::*;
#(
    parameter int LW = LW_DEFAULT
);

    logic          start;
    logic [LW-1:0] blk_len;
    logic [7:0]    tail_byte;

    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_rdy;

    logic [7:0]    q0;
    logic [7:0]    q1;
    logic [7:0]    q2;
    logic          out_valid;
    logic          out_rdy;

    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, blk_len, tail_byte, in_data, in_valid, out_rdy,
        input  in_rdy, q0, q1, q2, out_valid, busy, done, err
    );

    modport slave (
        input  start, blk_len, tail_byte, in_data, in_valid, out_rdy,
        output in_rdy, q0, q1, q2, out_valid, busy, done, err
    );

endinterface

// File: rtl/conv_encoder_param_out_fifo.sv
// First-word-fall-through FIFO holding encoded byte triplets {q2, q1, q0}.
// Head data reads as zero while empty so the outputs are clean after reset.
module conv_out_fifo
    import conv_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    always_comb begin
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        do_push = push && !full;
        do_pop  = pop && !empty;
        rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/conv_encoder_param.sv
// Tail-biting rate-1/3 convolutional encoder: one input bit per clock, LSB first, byte triplets out.
// Optional macro CONV_BLK_CNT_EN adds a 16-bit blk_cnt port counting completed blocks.
module conv_encoder_param
    import conv_pkg::*;
#(
    parameter int           K             = K_DEFAULT,
    parameter logic [K-1:0] G0            = K'(G0_DEFAULT),
    parameter logic [K-1:0] G1            = K'(G1_DEFAULT),
    parameter logic [K-1:0] G2            = K'(G2_DEFAULT),
    parameter int           MAX_LEN_BYTES = MAX_LEN_DEFAULT,
    parameter int           FIFO_DEPTH    = FIFO_DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    conv_encoder_param_if.slave  bus
`ifdef CONV_BLK_CNT_EN
    ,
    output logic [15:0]          blk_cnt
`endif
);

    localparam int            LW      = $clog2(MAX_LEN_BYTES + 1);
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_LEN_BYTES);
    localparam logic [LW-1:0] CNT_ONE = 1;

    conv_state_e   state;
    conv_state_e   state_nxt;

    logic [2:0]    bit_cnt;
    logic [7:0]    byte_r;
    logic [K-2:0]  hist;
    logic [K-2:0]  hist_pre;
    logic [LW-1:0] len_r;
    logic [LW-1:0] byte_cnt;
    logic [6:0]    acc0;
    logic [6:0]    acc1;
    logic [6:0]    acc2;
    logic          done_r;
    logic          err_r;

    logic          start_ok;
    logic          in_rdy_c;
    logic          accept;
    logic          advance;
    logic          push;
    logic          last_byte;
    logic          cur_bit;
    logic [K-1:0]  state_vec;
    logic          d0;
    logic          d1;
    logic          d2;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [23:0]   fifo_wdata;
    logic [23:0]   fifo_rdata;

    // Bit 0 of a byte is encoded straight from in_data on the accept clock,
    // which keeps the rate at exactly one byte per 8 clocks.
    always_comb begin
        start_ok   = bus.start && (bus.blk_len != '0) && (bus.blk_len <= MAX_LEN);
        in_rdy_c   = (state == ST_ENC) && (bit_cnt == '0) && !fifo_full;
        accept     = in_rdy_c && bus.in_valid;
        advance    = (state == ST_ENC) && ((bit_cnt != '0) || accept);
        cur_bit    = (bit_cnt == '0) ? bus.in_data[0] : byte_r[bit_cnt];
        state_vec  = {cur_bit, hist};
        d0         = ^(state_vec & G0);
        d1         = ^(state_vec & G1);
        d2         = ^(state_vec & G2);
        push       = advance && (bit_cnt == 3'd7);
        last_byte  = (byte_cnt == len_r);
        fifo_wdata = {d2, acc2, d1, acc1, d0, acc0};
        fifo_pop   = !fifo_empty && bus.out_rdy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_ENC;
            end
            ST_ENC: begin
                if (push && last_byte) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt  <= '0;
            byte_r   <= '0;
            hist     <= '0;
            hist_pre <= '0;
            len_r    <= '0;
            byte_cnt <= '0;
            acc0     <= '0;
            acc1     <= '0;
            acc2     <= '0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            done_r <= push && last_byte;
            err_r  <= (state == ST_IDLE) && bus.start && !start_ok;

            // tail_byte[7] is the most recent history bit, landing next to the current-bit tap.
            if ((state == ST_IDLE) && start_ok) begin
                len_r    <= bus.blk_len;
                hist_pre <= bus.tail_byte[7 -: K-1];
                byte_cnt <= '0;
            end

            if (state == ST_LOAD) begin
                hist    <= hist_pre;
                bit_cnt <= '0;
            end

            // Accumulators shift right so bit i of the finished byte is input bit i.
            if (advance) begin
                hist    <= state_vec[K-1:1];
                acc0    <= {d0, acc0[6:1]};
                acc1    <= {d1, acc1[6:1]};
                acc2    <= {d2, acc2[6:1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (accept) begin
                    byte_r   <= bus.in_data;
                    byte_cnt <= byte_cnt + CNT_ONE;
                end
            end
        end
    end

    conv_out_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        bus.in_rdy    = in_rdy_c;
        bus.out_valid = !fifo_empty;
        bus.q0        = fifo_rdata[7:0];
        bus.q1        = fifo_rdata[15:8];
        bus.q2        = fifo_rdata[23:16];
        bus.busy      = (state != ST_IDLE);
        bus.done      = done_r;
        bus.err       = err_r;
    end

`ifdef CONV_BLK_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_cnt <= '0;
        end else if (done_r) begin
            blk_cnt <= blk_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/conv_encoder_param.md
CONV_ENCODER_PARAM -- requirements
Module: conv_encoder_param

Interface
REQ-001 Parameter K, default 7: constraint length, legal range 5..9.
REQ-002 Parameter G0, default 7'o133: generator 0, K bits, MSB taps current input.
REQ-003 Parameter G1, default 7'o171: generator 1.
REQ-004 Parameter G2, default 7'o165: generator 2.
REQ-005 Parameter MAX_LEN_BYTES, default 768: largest block in bytes; length port width LW = clog2(MAX_LEN_BYTES+1).
REQ-006 Parameter FIFO_DEPTH, default 16: output FIFO depth in byte triplets, power of two.
REQ-007 clk  in  1  sole clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  one-cycle pulse that opens a block.
REQ-010 blk_len  in  LW  block length in bytes, sampled with start.
REQ-011 tail_byte  in  8  last input byte of the block, sampled with start.
REQ-012 in_data, in_valid, in_rdy  in/in/out  8/1/1  input byte stream.
REQ-013 q0, q1, q2  out  8 each  encoded bytes for streams 0..2.
REQ-014 out_valid, out_rdy  out/in  1/1  output triplet handshake.
REQ-015 busy, done, err  out  1 each  status; done and err are one-cycle pulses.

Function
REQ-016 Encoding SHALL be tail-biting rate 1/3: each input bit produces three bits dn = XOR of state bits selected by Gn.
- State = [current bit, previous K-1 bits].
REQ-017 Input bits SHALL be consumed LSB first.
- Output byte bit i SHALL be the result for input bit i.
REQ-018 FSM states: IDLE, LOAD, ENC, DRAIN.
- IDLE->LOAD on start with 1 <= blk_len <= MAX_LEN_BYTES.
- LOAD->ENC after 1 cycle.
- ENC->DRAIN after the last bit of byte blk_len.
- DRAIN->IDLE when the FIFO is empty.
REQ-019 LOAD SHALL preset the K-1 history bits to tail_byte[7], tail_byte[6], ... (most recent first).
REQ-020 ENC SHALL process one bit per clock.
- A byte is accepted (in_rdy=1) only at a byte boundary, only if the FIFO is not full.
- Throughput is one byte per 8 clocks.
REQ-021 in_valid low or FIFO full at a byte boundary SHALL stall with state and bit counter held.
REQ-022 The completed triplet SHALL be written to the FIFO on the clock the 8th bit is encoded.
REQ-023 out_valid = FIFO not empty.
- A pop occurs when out_valid and out_rdy are both 1.
- q0..q2 show the FIFO head (first-word-fall-through).
REQ-024 done SHALL pulse the cycle after the last triplet is written.
REQ-025 busy = state != IDLE.
REQ-026 start while busy SHALL be ignored with no err.
REQ-027 start with blk_len 0 or blk_len > MAX_LEN_BYTES SHALL pulse err the next cycle and remain in IDLE.
REQ-028 Simultaneous FIFO push and pop SHALL keep the occupancy unchanged.
REQ-029 The byte counter SHALL be LW bits and SHALL NOT wrap within a legal block.

Reset
REQ-030 reset SHALL override all other inputs, including mid-block, and the next cycle SHALL show:
- state IDLE, history zero, FIFO emptied;
- in_rdy=0, out_valid=0, busy=0, done=0, err=0, q0..q2=0.

Configuration
REQ-031 With macro CONV_BLK_CNT_EN defined:
- add output port blk_cnt (16 bits), counting done pulses, wrapping FFFF->0000, cleared by reset.
REQ-032 Without CONV_BLK_CNT_EN the port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-033 A shared package conv_pkg SHALL hold:
- the FSM state enum;
- default generator constants (133, 171, 165 octal);
- K_DEFAULT.
REQ-034 The output FIFO SHALL be one sub-module, conv_out_fifo, 24 bits wide by FIFO_DEPTH, instantiated once (not once per stream).

Verification
REQ-035 blk_len=1, tail 0x00, data 0x01 -> q0=0x6D, q1=0x4F, q2=0x57; done 1 cycle after the write.
REQ-036 blk_len=4, all data 0x00, tail 0x00 -> four triplets of 0x00/0x00/0x00, done once.
REQ-037 blk_len=768, random data, out_rdy held low -> in_rdy drops after FIFO_DEPTH triplets; output matches the model after out_rdy rises.
REQ-038 start with blk_len=0 -> err pulse, busy stays 0; start while busy -> no effect.
REQ-039 reset asserted during byte 3 of 8 -> the next cycle is all IDLE values; a following block encodes correctly.
REQ-040 CONV_BLK_CNT_EN defined, 3 blocks run -> blk_cnt=3.
